// File: rtl/hit_timestamp_fifo.sv
// Hit timestamping front end: synchronises discriminator hits, tags edges with a 24-bit time
// counter and queues {mask, timestamp} words in a show-ahead FIFO. Optional TIMESTAMP_WRAP_MARKER_EN.
module hit_timestamp_fifo #(
  parameter int N_CH       = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            clk_50,
  input  logic            rst,
  input  logic            rst_time,
  input  logic            enable_acq,
  input  logic [N_CH-1:0] hit_in,
  input  logic            rd_en,
  output logic [31:0]     fifo_data,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic [15:0]     overflow_cnt,
  output logic [23:0]     time_cnt
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [N_CH-1:0] sync1, sync2, sync3;
  logic [N_CH-1:0] hit_edge;
  logic [7:0]      hit_mask;
  logic            hit_wr;
  logic            wrap_now;
  logic            wr_req;
  logic [31:0]     wr_data;
  logic            do_pop;
  logic            do_push;
  logic            drop;

  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;

  // sync1/sync2 resolve metastability; sync3 holds the previous settled level for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= hit_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign hit_edge = sync2 & ~sync3;
  assign hit_mask = 8'(hit_edge);
  assign hit_wr   = enable_acq & (|hit_edge);
  assign wrap_now = enable_acq & ~rst_time & (time_cnt == 24'hFF_FFFF);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      time_cnt <= '0;
    end else if (rst_time) begin
      time_cnt <= '0;
    end else if (enable_acq) begin
      time_cnt <= time_cnt + 24'd1;
    end
  end

`ifdef TIMESTAMP_WRAP_MARKER_EN
  logic [23:0] wrap_cnt;
  logic        marker_pend;
  logic        marker_req;

  assign marker_req = wrap_now | marker_pend;

  // A hit word owns the write port; a colliding marker waits one cycle in marker_pend.
  always_comb begin
    wr_req  = hit_wr | marker_req;
    wr_data = {hit_mask, time_cnt};
    if (!hit_wr && marker_req) begin
      wr_data = {8'h00, (wrap_now ? wrap_cnt + 24'd1 : wrap_cnt)};
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wrap_cnt    <= '0;
      marker_pend <= 1'b0;
    end else if (rst_time) begin
      wrap_cnt    <= '0;
      marker_pend <= 1'b0;
    end else begin
      if (wrap_now) begin
        wrap_cnt <= wrap_cnt + 24'd1;
      end
      marker_pend <= hit_wr & marker_req;
    end
  end
`else
  always_comb begin
    wr_req  = hit_wr;
    wr_data = {hit_mask, time_cnt};
  end
`endif

  // Pointers carry one extra bit so full and empty are distinguishable with equal indices.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign fifo_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A pop frees the head slot in the same edge, so a full FIFO can still accept a write.
  assign do_pop  = rd_en & ~fifo_empty;
  assign do_push = wr_req & (~fifo_full | do_pop);
  assign drop    = wr_req & fifo_full & ~do_pop;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: storage is not reset; clearing the pointers is enough to make old words unreachable.
  always_ff @(posedge clk_50) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (rst_time) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hit_timestamp_fifo.sv
// Directed self-checking bench for hit_timestamp_fifo (default N_CH=8, DEPTH_LOG2=4).
// Inputs change and outputs are sampled 1 ns after each rising clk_50 edge.
module tb_hit_timestamp_fifo;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic        rst_time = 1'b0;
  logic        enable_acq = 1'b0;
  logic [7:0]  hit_in = '0;
  logic        rd_en = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] overflow_cnt;
  logic [23:0] time_cnt;

  int checks = 0;
  int errors = 0;

  hit_timestamp_fifo #(.N_CH(8), .DEPTH_LOG2(4)) dut (
    .clk_50       (clk_50),
    .rst          (rst),
    .rst_time     (rst_time),
    .enable_acq   (enable_acq),
    .hit_in       (hit_in),
    .rd_en        (rd_en),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow_cnt (overflow_cnt),
    .time_cnt     (time_cnt)
  );

  always #10 clk_50 = ~clk_50;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state while rst is held
    #5;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_time", 32'(time_cnt), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    tick(2);

    // Single channel-2 pulse, 3 cycles wide: one word 3 edges after the rise
    rst = 1'b0; enable_acq = 1'b1; hit_in = 8'h04;
    tick();
    check("ch2_empty_e1", 32'(fifo_empty), 32'd1);
    tick();
    check("ch2_empty_e2", 32'(fifo_empty), 32'd1);
    tick();
    check("ch2_empty_e3", 32'(fifo_empty), 32'd0);
    check("ch2_word", fifo_data, {8'h04, 24'd2});
    hit_in = 8'h00;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("ch2_single_word", 32'(fifo_empty), 32'd1);
    check("time_after_5", 32'(time_cnt), 32'd5);

    // Channels 0 and 5 rising together merge into one word
    hit_in = 8'h21;
    tick();
    hit_in = 8'h00;
    tick(2);
    check("merge_empty", 32'(fifo_empty), 32'd0);
    check("merge_word", fifo_data, {8'h21, 24'd7});
    rd_en = 1'b1;
    tick();
    check("merge_popped", 32'(fifo_empty), 32'd1);
    tick();
    rd_en = 1'b0;
    check("pop_empty_ignored", 32'(fifo_empty), 32'd1);
    check("pop_empty_full", 32'(fifo_full), 32'd0);

    // 20 back-to-back hits without reads: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) begin
      hit_in = (i % 2 == 1) ? 8'h02 : 8'h01;
      tick();
    end
    hit_in = 8'h00;
    tick(3);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_count", 32'(overflow_cnt), 32'd4);
    check("ovf_head", fifo_data, {8'h01, 24'd12});
    check("ovf_time", 32'(time_cnt), 32'd33);

    // rst_time clears counters but keeps the stored words
    rst_time = 1'b1;
    tick();
    rst_time = 1'b0;
    check("rsttime_time", 32'(time_cnt), 32'd0);
    check("rsttime_ovf", 32'(overflow_cnt), 32'd0);
    check("rsttime_full", 32'(fifo_full), 32'd1);
    check("rsttime_head", fifo_data, {8'h01, 24'd12});
    tick();
    check("rsttime_count", 32'(time_cnt), 32'd1);

    // A hit outside the acquisition window is discarded (a write would count as overflow)
    enable_acq = 1'b0; hit_in = 8'h80;
    tick();
    hit_in = 8'h00;
    tick(2);
    check("noacq_ovf", 32'(overflow_cnt), 32'd0);
    check("noacq_time_hold", 32'(time_cnt), 32'd1);
    check("noacq_full", 32'(fifo_full), 32'd1);

    // Drain, checking order and timestamps
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      check($sformatf("drain_%0d", i), fifo_data,
            {((i % 2 == 1) ? 8'h02 : 8'h01), 24'(12 + i)});
      tick();
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(fifo_empty), 32'd1);

    // 17 hits; the 17th arrives while full with a same-cycle pop
    enable_acq = 1'b1;
    for (int i = 0; i < 17; i++) begin
      hit_in = (i % 2 == 1) ? 8'h02 : 8'h01;
      tick();
    end
    hit_in = 8'h00;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fullpop_full", 32'(fifo_full), 32'd1);
    check("fullpop_ovf", 32'(overflow_cnt), 32'd0);
    check("fullpop_head", fifo_data, {8'h02, 24'd4});
    rd_en = 1'b1;
    tick(15);
    rd_en = 1'b0;
    check("fullpop_tail", fifo_data, {8'h01, 24'd19});
    check("fullpop_not_full", 32'(fifo_full), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fullpop_drained", 32'(fifo_empty), 32'd1);

    // Write and pop in the same cycle while empty: write kept, pop ignored
    hit_in = 8'h10;
    tick();
    hit_in = 8'h00;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("emptypop_empty", 32'(fifo_empty), 32'd0);
    check("emptypop_word", fifo_data, {8'h10, 24'd38});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("emptypop_drained", 32'(fifo_empty), 32'd1);

    // Asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) begin
      hit_in = (i % 2 == 1) ? 8'h02 : 8'h01;
      tick();
    end
    hit_in = 8'h00;
    tick(3);
    check("five_empty", 32'(fifo_empty), 32'd0);
    check("five_head", fifo_data, {8'h01, 24'd42});
    #2 rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(fifo_empty), 32'd1);
    check("async_rst_time", 32'(time_cnt), 32'd0);
    check("async_rst_full", 32'(fifo_full), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_empty", 32'(fifo_empty), 32'd1);
    check("post_rst_time", 32'(time_cnt), 32'd1);

`ifdef TIMESTAMP_WRAP_MARKER_EN
    // Hit written on the wrap edge, marker follows on the next cycle
    force dut.time_cnt = 24'hFF_FFFD;
    hit_in = 8'h08;
    #1 release dut.time_cnt;
    tick();
    hit_in = 8'h00;
    tick(2);
    check("wrap_hit_word", fifo_data, {8'h08, 24'hFF_FFFF});
    check("wrap_time", 32'(time_cnt), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("wrap_marker", fifo_data, 32'h0000_0001);
    check("wrap_marker_present", 32'(fifo_empty), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_timestamp_fifo.md
HIT_TIMESTAMP_FIFO -- requirements
Module: hit_timestamp_fifo

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of hit input channels, range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 words.
REQ-003 SHALL have port clk_50  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rst_time  input  1  synchronous clear of the time counter and the overflow counter, driven by the DAQ state-sync stage.
REQ-006 SHALL have port enable_acq  input  1  acquisition window; high enables counting and recording.
REQ-007 SHALL have port hit_in  input  N_CH  asynchronous discriminator hits, one per channel.
REQ-008 SHALL have port rd_en  input  1  HPS pop strobe, one word per high cycle.
REQ-009 SHALL have port fifo_data  output  32  head word {8-bit channel mask, 24-bit timestamp}; unused mask bits 0.
REQ-010 SHALL have port fifo_empty  output  1  FIFO holds no word.
REQ-011 SHALL have port fifo_full  output  1  FIFO holds 2^DEPTH_LOG2 words.
REQ-012 SHALL have port overflow_cnt  output  16  words dropped because the FIFO was full.
REQ-013 SHALL have port time_cnt  output  24  current timestamp counter.

Function
REQ-014 SHALL pass each hit_in bit through a 2-flop synchroniser, then a third flop for rising-edge detection.
REQ-015 SHALL write the channel mask at clk_50 edge k+2 when hit_in rises before edge k; simultaneous edges on several channels SHALL merge into one word.
REQ-016 SHALL clear time_cnt to 0 on rst_time; otherwise increment by 1 per cycle while enable_acq=1, wrapping 0xFFFFFF->0; hold while enable_acq=0.
REQ-017 SHALL record as timestamp the time_cnt value present in the write cycle, before that cycle's increment.
REQ-018 SHALL write hit words only while enable_acq=1; edges detected while enable_acq=0 SHALL be discarded.
REQ-019 SHALL present the head word on fifo_data combinationally (show-ahead); fifo_data is don't-care while fifo_empty=1.
REQ-020 SHALL remove the head word at the edge where rd_en=1 and fifo_empty=0; rd_en while empty SHALL be ignored.
REQ-021 SHALL drop a write when full without a same-cycle pop, and increment overflow_cnt, saturating at 0xFFFF.
REQ-022 SHALL, on simultaneous write and pop while full, accept both with occupancy unchanged and no overflow.
REQ-023 SHALL, on simultaneous write and pop while empty, accept the write and ignore the pop.
REQ-024 SHALL clear overflow_cnt on rst_time; FIFO contents SHALL NOT be affected by rst_time.
REQ-025 SHALL give rst_time priority over enable_acq when both are high (time_cnt becomes 0).

Reset
REQ-026 SHALL, on rst, asynchronously set time_cnt=0, overflow_cnt=0, fifo_empty=1, fifo_full=0, read/write pointers=0, synchroniser flops=0, and the wrap counter and marker-pending flag=0.
REQ-027 SHALL, on rst mid-operation, discard all stored words; no partial word SHALL remain after reset release.

Configuration
REQ-028 SHALL, with macro TIMESTAMP_WRAP_MARKER_EN defined, keep a 24-bit wrap counter incremented on each time_cnt wrap and write a marker word {8'h00, wrap counter after increment} on that wrap.
REQ-029 SHALL, with TIMESTAMP_WRAP_MARKER_EN, give a hit word priority over a same-cycle marker and write the marker in the next cycle (pending flag); markers follow the same full/overflow rules; rst_time clears the wrap counter.
REQ-030 SHALL, without TIMESTAMP_WRAP_MARKER_EN, include no wrap counter and no markers; wrap is silent.

Verification
REQ-031 Reset release, enable_acq=1, hit_in[2] pulse 3 cycles wide -> exactly one word, mask 0x04, timestamp = time_cnt at write; fifo_empty low 3 edges after pulse rise.
REQ-032 hit_in[0] and hit_in[5] rise in the same cycle -> single word with mask 0x21.
REQ-033 DEPTH_LOG2=4, 20 hits with no reads -> fifo_full=1, overflow_cnt=4; with rd_en held high on the 17th hit -> that hit is stored with no extra overflow.
REQ-034 rst_time pulse during acquisition -> time_cnt=0 next cycle, overflow_cnt=0, stored words retained; hit with enable_acq=0 -> no write.
REQ-035 With TIMESTAMP_WRAP_MARKER_EN, time_cnt forced near 0xFFFFFF and a hit timed onto the wrap edge -> hit word then marker 0x00000001 on consecutive cycles.
REQ-036 rst asserted with 5 words stored -> fifo_empty=1 and time_cnt=0 immediately, before the next clock edge.
